// File: rtl/result_trace_buffer.sv
// result_trace_buffer: captures per-lane writeback results into a DEPTH-entry ring
// and lets the board freeze the ring and step through its history with two buttons.
module result_trace_buffer #(
    parameter int unsigned LANES = 2,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           hz100,
    input  logic                           reset,
    input  logic                           en,
    input  logic [LANES-1:0]               lane_valid,
    input  logic [LANES*WIDTH-1:0]         lane_data,
    input  logic                           hold,
    input  logic                           clear,
    input  logic                           btn_back,
    input  logic                           btn_fwd,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] sel_lane,
    output logic [WIDTH-1:0]               disp_data,
    output logic                           disp_valid,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [$clog2(DEPTH)-1:0]       offset,
    output logic                           wrapped
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Ring storage; contents are never reset, validity is tracked by r_count.
    logic [LANES-1:0]       r_mem_mask [DEPTH];
    logic [LANES*WIDTH-1:0] r_mem_data [DEPTH];

    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_offset;
    logic             r_wrapped;
    logic             r_prev_back;
    logic             r_prev_fwd;
    logic [WIDTH-1:0] r_disp_data;
    logic             r_disp_valid;

    logic                   w_rise_back;
    logic                   w_rise_fwd;
    logic                   w_write;
    logic                   w_full;
    logic [PW-1:0]          w_rd_addr;
    logic [PW-1:0]          w_offset_d;
    logic [CW-1:0]          w_offset_ext;
    logic [LANES-1:0]       w_entry_mask;
    logic [LANES*WIDTH-1:0] w_entry_data;
    logic [WIDTH-1:0]       w_disp_data;
    logic                   w_disp_valid;

    // Write qualification, button edges and view address.
    always_comb begin
        w_rise_back  = btn_back & ~r_prev_back;
        w_rise_fwd   = btn_fwd & ~r_prev_fwd;
        w_write      = en & ~hold & ~clear & (|lane_valid);
        w_full       = (r_count == CW'(DEPTH));
        w_rd_addr    = r_wr_ptr - PW'(1) - r_offset;
        w_offset_ext = CW'(r_offset);
    end

    // Browse offset: forced to newest when live, clamped to [0, count-1] when held.
    always_comb begin
        w_offset_d = r_offset;
        if (!hold || (r_count == '0)) begin
            w_offset_d = '0;
        end else if (w_rise_back && !w_rise_fwd) begin
            if ((w_offset_ext + CW'(1)) < r_count) begin
                w_offset_d = r_offset + PW'(1);
            end
        end else if (w_rise_fwd && !w_rise_back) begin
            if (r_offset != '0) begin
                w_offset_d = r_offset - PW'(1);
            end
        end
    end

    // Select the viewed entry's lane; out-of-range lanes and an empty ring show zero.
    always_comb begin
        w_entry_mask = r_mem_mask[w_rd_addr];
        w_entry_data = r_mem_data[w_rd_addr];
        w_disp_data  = '0;
        w_disp_valid = 1'b0;
        if (r_count != '0) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (int'(sel_lane) == i) begin
                    w_disp_data  = w_entry_data[i*WIDTH +: WIDTH];
                    w_disp_valid = w_entry_mask[i];
                end
            end
        end
    end

    // Ring storage write port.
    always_ff @(posedge hz100) begin
        if (!reset && w_write) begin
            r_mem_mask[r_wr_ptr] <= lane_valid;
            r_mem_data[r_wr_ptr] <= lane_data;
        end
    end

    // Control state: pointers, occupancy, view offset, button history and display.
    always_ff @(posedge hz100) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_offset     <= '0;
            r_wrapped    <= 1'b0;
            r_prev_back  <= 1'b0;
            r_prev_fwd   <= 1'b0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_prev_back  <= btn_back;
            r_prev_fwd   <= btn_fwd;
            r_disp_data  <= w_disp_data;
            r_disp_valid <= w_disp_valid;
            if (clear) begin
                r_wr_ptr  <= '0;
                r_count   <= '0;
                r_offset  <= '0;
                r_wrapped <= 1'b0;
            end else begin
                r_offset <= w_offset_d;
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                    if (w_full) begin
                        r_wrapped <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
            end
        end
    end

    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign count      = r_count;
    assign offset     = r_offset;
    assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_result_trace_buffer.sv
// Bench for result_trace_buffer: history-based reference model feeding a scoreboard,
// plus directed checks from the test plan and a LANES=3 build for lane range.
module tb_result_trace_buffer;

    localparam int DEPTH = 8;

    logic        hz100 = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  lane_valid = '0;
    logic [63:0] lane_data = '0;
    logic        hold = 1'b0;
    logic        clear = 1'b0;
    logic        btn_back = 1'b0;
    logic        btn_fwd = 1'b0;
    logic [0:0]  sel_lane = '0;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic [3:0]  count;
    logic [2:0]  offset;
    logic        wrapped;

    // Second build with three lanes so sel_lane can exceed LANES-1.
    logic        b_en = 1'b0;
    logic [2:0]  b_lane_valid = '0;
    logic [95:0] b_lane_data = '0;
    logic [1:0]  b_sel_lane = '0;
    logic        b_zero = 1'b0;
    logic [31:0] b_disp_data;
    logic        b_disp_valid;
    logic [3:0]  b_count;
    logic [2:0]  b_offset;
    logic        b_wrapped;

    int n_vec = 0;
    int n_err = 0;

    always #5 hz100 = ~hz100;

    result_trace_buffer #(.LANES(2), .WIDTH(32), .DEPTH(DEPTH)) u_dut (
        .hz100(hz100), .reset(reset), .en(en), .lane_valid(lane_valid),
        .lane_data(lane_data), .hold(hold), .clear(clear), .btn_back(btn_back),
        .btn_fwd(btn_fwd), .sel_lane(sel_lane), .disp_data(disp_data),
        .disp_valid(disp_valid), .count(count), .offset(offset), .wrapped(wrapped)
    );

    result_trace_buffer #(.LANES(3), .WIDTH(32), .DEPTH(DEPTH)) u_dut3 (
        .hz100(hz100), .reset(reset), .en(b_en), .lane_valid(b_lane_valid),
        .lane_data(b_lane_data), .hold(b_zero), .clear(b_zero), .btn_back(b_zero),
        .btn_fwd(b_zero), .sel_lane(b_sel_lane), .disp_data(b_disp_data),
        .disp_valid(b_disp_valid), .count(b_count), .offset(b_offset), .wrapped(b_wrapped)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: history of accepted writes (newest at back, at most DEPTH kept).
    logic [65:0] m_hist[$];
    int          m_off = 0;
    logic        m_wrapped = 1'b0;
    logic        m_pb = 1'b0;
    logic        m_pf = 1'b0;
    logic [32:0] exp_q[$];

    always @(posedge hz100) begin
        int          cnt;
        logic [65:0] e;
        logic        rb;
        logic        rf;
        cnt = m_hist.size();
        // Expected display for this edge comes from the state before the edge.
        if (reset || cnt == 0) begin
            exp_q.push_back(33'd0);
        end else begin
            e = m_hist[cnt - 1 - m_off];
            exp_q.push_back({e[64 + sel_lane], e[sel_lane*32 +: 32]});
        end
        rb = btn_back & ~m_pb;
        rf = btn_fwd & ~m_pf;
        m_pb = btn_back;
        m_pf = btn_fwd;
        if (reset) begin
            m_hist.delete();
            m_off = 0;
            m_wrapped = 1'b0;
            m_pb = 1'b0;
            m_pf = 1'b0;
        end else if (clear) begin
            m_hist.delete();
            m_off = 0;
            m_wrapped = 1'b0;
        end else begin
            if (!hold || cnt == 0) m_off = 0;
            else if (rb && !rf) m_off = (m_off + 1 > cnt - 1) ? cnt - 1 : m_off + 1;
            else if (rf && !rb) m_off = (m_off > 0) ? m_off - 1 : 0;
            if (en && !hold && (|lane_valid)) begin
                if (cnt == DEPTH) m_wrapped = 1'b1;
                m_hist.push_back({lane_valid, lane_data});
                if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
            end
        end
    end

    // Scoreboard: compare every registered output against the model each cycle.
    always @(negedge hz100) begin
        logic [32:0] x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check_eq("sb_disp_data", 64'(disp_data), 64'(x[31:0]));
            check_eq("sb_disp_valid", 64'(disp_valid), 64'(x[32]));
            check_eq("sb_count", 64'(count), 64'(m_hist.size()));
            check_eq("sb_offset", 64'(offset), 64'(m_off));
            check_eq("sb_wrapped", 64'(wrapped), 64'(m_wrapped));
        end
    end

    task automatic step();
        @(posedge hz100);
        #1;
    endtask

    task automatic strobe(input logic [1:0] lv, input logic [31:0] d1, input logic [31:0] d0);
        en = 1'b1;
        lane_valid = lv;
        lane_data = {d1, d0};
        step();
        en = 1'b0;
        lane_valid = '0;
    endtask

    task automatic press_back();
        btn_back = 1'b1;
        step();
        btn_back = 1'b0;
        step();
    endtask

    task automatic press_fwd();
        btn_fwd = 1'b1;
        step();
        btn_fwd = 1'b0;
        step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        @(negedge hz100);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_disp_valid", 64'(disp_valid), 64'd0);

        // Three writes, newest visible two cycles after the last strobe.
        for (int i = 1; i <= 3; i++) strobe(2'b11, 32'h100 + i, i);
        step();
        @(negedge hz100);
        check_eq("t1_count", 64'(count), 64'd3);
        check_eq("t1_offset", 64'(offset), 64'd0);
        check_eq("t1_disp", 64'(disp_data), 64'd3);
        check_eq("t1_valid", 64'(disp_valid), 64'd1);

        // Ten writes wrap the ring; browse back to the oldest surviving entry.
        pulse_clear();
        for (int i = 1; i <= 10; i++) strobe(2'b11, 32'h200 + i, i);
        @(negedge hz100);
        check_eq("t2_count", 64'(count), 64'd8);
        check_eq("t2_wrapped", 64'(wrapped), 64'd1);
        hold = 1'b1;
        step();
        for (int i = 0; i < 7; i++) press_back();
        step();
        @(negedge hz100);
        check_eq("t2_offset7", 64'(offset), 64'd7);
        check_eq("t2_disp_oldest", 64'(disp_data), 64'd3);
        press_back();
        @(negedge hz100);
        check_eq("t2_offset_clamp", 64'(offset), 64'd7);
        press_fwd();
        step();
        @(negedge hz100);
        check_eq("t2_disp_fwd", 64'(disp_data), 64'd4);

        // Writes while held are dropped; releasing hold returns to newest.
        strobe(2'b11, 32'h99, 32'h99);
        @(negedge hz100);
        check_eq("t3_count_held", 64'(count), 64'd8);
        hold = 1'b0;
        step();
        step();
        @(negedge hz100);
        check_eq("t3_offset_live", 64'(offset), 64'd0);
        check_eq("t3_disp_newest", 64'(disp_data), 64'd10);

        // Lane 1 invalid in this entry: data still shown, valid low.
        sel_lane = 1'b1;
        strobe(2'b01, 32'hDEAD, 32'h11);
        step();
        @(negedge hz100);
        check_eq("t4_valid_lane1", 64'(disp_valid), 64'd0);
        check_eq("t4_data_lane1", 64'(disp_data), 64'hDEAD);
        sel_lane = 1'b0;

        // clear wins over a simultaneous write.
        clear = 1'b1;
        en = 1'b1;
        lane_valid = 2'b01;
        step();
        clear = 1'b0;
        en = 1'b0;
        lane_valid = '0;
        @(negedge hz100);
        check_eq("t5_count_clr", 64'(count), 64'd0);
        check_eq("t5_wrapped_clr", 64'(wrapped), 64'd0);
        step();
        @(negedge hz100);
        check_eq("t5_valid_clr", 64'(disp_valid), 64'd0);

        // Simultaneous back and fwd edges cancel.
        for (int i = 1; i <= 3; i++) strobe(2'b11, 32'h300 + i, 32'h30 + i);
        hold = 1'b1;
        press_back();
        btn_back = 1'b1;
        btn_fwd = 1'b1;
        step();
        btn_back = 1'b0;
        btn_fwd = 1'b0;
        @(negedge hz100);
        check_eq("t5_both_edges", 64'(offset), 64'd1);

        // Reset mid-browse clears everything on the next cycle.
        hold = 1'b0;
        pulse_clear();
        for (int i = 1; i <= 5; i++) strobe(2'b11, 32'h400 + i, 32'h40 + i);
        hold = 1'b1;
        press_back();
        press_back();
        @(negedge hz100);
        check_eq("t6_offset2", 64'(offset), 64'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge hz100);
        check_eq("t6_rst_count", 64'(count), 64'd0);
        check_eq("t6_rst_offset", 64'(offset), 64'd0);
        check_eq("t6_rst_disp", 64'(disp_data), 64'd0);
        check_eq("t6_rst_valid", 64'(disp_valid), 64'd0);

        // A button held high for many cycles steps only once.
        hold = 1'b0;
        for (int i = 1; i <= 3; i++) strobe(2'b11, 32'h500 + i, 32'h50 + i);
        hold = 1'b1;
        btn_back = 1'b1;
        repeat (20) step();
        @(negedge hz100);
        check_eq("t6_held_button", 64'(offset), 64'd1);
        btn_back = 1'b0;
        hold = 1'b0;
        step();

        // Three-lane build: lane 2 masked off, sel_lane=3 out of range.
        b_en = 1'b1;
        b_lane_valid = 3'b011;
        b_lane_data = {32'h3333, 32'h2222, 32'h1111};
        step();
        b_en = 1'b0;
        b_lane_valid = '0;
        step();
        @(negedge hz100);
        check_eq("l3_count", 64'(b_count), 64'd1);
        check_eq("l3_sel0_data", 64'(b_disp_data), 64'h1111);
        check_eq("l3_sel0_valid", 64'(b_disp_valid), 64'd1);
        b_sel_lane = 2'd2;
        step();
        @(negedge hz100);
        check_eq("l3_sel2_data", 64'(b_disp_data), 64'h3333);
        check_eq("l3_sel2_valid", 64'(b_disp_valid), 64'd0);
        b_sel_lane = 2'd3;
        step();
        @(negedge hz100);
        check_eq("l3_sel3_data", 64'(b_disp_data), 64'd0);
        check_eq("l3_sel3_valid", 64'(b_disp_valid), 64'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
